weight_loader: RTL

- Write-side counterpart to weight_mem: receives a byte stream (host or UART front-end) and writes assembled weights into the weight memories of one layer.
- Assembles data_width-bit words from little-endian bytes.
- Walks addresses 0..num_weight-1 for each neuron 0..num_neuron-1.
- Drives a shared write bus (w_en, w_add, w_in) plus a neuron select that steers w_en to one weight_mem instance.

---
 rtl/weight_loader_if.sv | 32 +++
 rtl/weight_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/weight_loader_if.sv
// weight_loader_if
//   Groups the byte-stream handshake and the shared weight-memory write bus.
//   master : the loader (consumes bytes, drives the write bus)
//   slave  : the environment (byte source, weight memories)
//   Signals:
//     in_valid, in_data[7:0]  byte from the host / UART front-end
//     in_ready                loader accepts a byte this cycle
//     w_en, w_add, w_in       write strobe, address and assembled weight
//     n_sel                   target neuron memory index
interface weight_loader_if #(
    parameter int address_width = 2,
    parameter int data_width    = 16,
    parameter int neuron_width  = 1
);
    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic                     w_en;
    logic [address_width-1:0] w_add;
    logic [data_width-1:0]    w_in;
    logic [neuron_width-1:0]  n_sel;

    modport master (
        input  in_valid, in_data,
        output in_ready, w_en, w_add, w_in, n_sel
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, w_en, w_add, w_in, n_sel
    );
endinterface

// File: rtl/weight_loader.sv
// weight_loader
//   Receives a little-endian byte stream and writes the assembled weights of
//   one layer into its weight memories, neuron by neuron, address by address.
//   Ports:
//     clk, rst_n   clock (rising edge), synchronous active-low reset
//     start        single-cycle pulse, starts a layer load from IDLE
//     abort        drops the load in progress
//     bus          weight_loader_if.master (byte stream in, write bus out)
//     busy         load in progress
//     done         one-cycle pulse when the whole layer has been written
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | waiting for start, byte stream not accepted
//   COLLECT | accepting bytes into the word register
//   WRITE   | w_en high for one cycle, indices advance after it
//   DONE    | one-cycle done pulse, then back to IDLE
module weight_loader #(
    parameter int num_weight    = 3,
    parameter int address_width = 2,
    parameter int data_width    = 16,
    parameter int num_neuron    = 2,
    parameter int neuron_width  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    weight_loader_if.master   bus,
    output logic              busy,
    output logic              done
);
    localparam int BYTES = data_width / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BW-1:0]            LAST_BYTE   = BW'(BYTES - 1);
    localparam logic [address_width-1:0] LAST_ADD    = address_width'(num_weight - 1);
    localparam logic [neuron_width-1:0]  LAST_NEURON = neuron_width'(num_neuron - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]               state_q,    state_d;
    logic [BW-1:0]            byte_cnt_q, byte_cnt_d;
    logic [data_width-1:0]    word_q,     word_d;
    logic [address_width-1:0] w_add_q,    w_add_d;
    logic [neuron_width-1:0]  n_sel_q,    n_sel_d;
    logic                     in_ready_q, in_ready_d;
    logic                     w_en_q,     w_en_d;
    logic                     busy_q,     busy_d;
    logic                     done_q,     done_d;
    logic                     hs;

    // in_ready_q is high exactly while in COLLECT, so it qualifies the handshake
    assign hs = bus.in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        w_add_d    = w_add_q;
        n_sel_d    = n_sel_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = COLLECT;
                    byte_cnt_d = '0;
                    w_add_d    = '0;
                    n_sel_d    = '0;
                end
            end
            COLLECT: begin
                // abort wins over a simultaneous last-byte handshake
                if (abort) begin
                    state_d    = IDLE;
                    byte_cnt_d = '0;
                    w_add_d    = '0;
                    n_sel_d    = '0;
                end else if (hs) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                // the write itself is already on the bus; abort only stops what follows
                byte_cnt_d = '0;
                if (abort) begin
                    state_d = IDLE;
                    w_add_d = '0;
                    n_sel_d = '0;
                end else if (w_add_q == LAST_ADD) begin
                    w_add_d = '0;
                    if (n_sel_q == LAST_NEURON) begin
                        n_sel_d = '0;
                        state_d = DONE;
                    end else begin
                        n_sel_d = n_sel_q + 1'b1;
                        state_d = COLLECT;
                    end
                end else begin
                    w_add_d = w_add_q + 1'b1;
                    state_d = COLLECT;
                end
            end
            DONE: begin
                state_d = IDLE;
                w_add_d = '0;
                n_sel_d = '0;
            end
            default: begin
                state_d    = IDLE;
                byte_cnt_d = '0;
                w_add_d    = '0;
                n_sel_d    = '0;
            end
        endcase
    end

    // status outputs are registered copies of the next-state decode
    always_comb begin
        in_ready_d = (state_d == COLLECT);
        w_en_d     = (state_d == WRITE);
        busy_d     = (state_d == COLLECT) || (state_d == WRITE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_q     <= '0;
            w_add_q    <= '0;
            n_sel_q    <= '0;
            in_ready_q <= 1'b0;
            w_en_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            w_add_q    <= w_add_d;
            n_sel_q    <= n_sel_d;
            in_ready_q <= in_ready_d;
            w_en_q     <= w_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.w_en     = w_en_q;
    assign bus.w_add    = w_add_q;
    assign bus.w_in     = word_q;
    assign bus.n_sel    = n_sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule
